// File: rtl/parallel_io_bank.sv
// Memory-mapped parallel I/O bank: N_OUT output registers, N_IN synchronised input channels
// with sticky change flags. Define PIO_DEBOUNCE_EN to add the per-channel debouncer.
module parallel_io_bank #(
    parameter int unsigned        DATA_W     = 8,
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        N_OUT      = 2,
    parameter int unsigned        N_IN       = 2,
    parameter logic [ADDR_W-1:0]  OUT_BASE   = 8'hF8,
    parameter logic [ADDR_W-1:0]  IN_BASE    = 8'hF0,
    parameter logic [ADDR_W-1:0]  STAT_ADDR  = 8'hEF,
    parameter int unsigned        DEB_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic [N_IN*DATA_W-1:0]  din,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_OUT*DATA_W-1:0] dout,
    output logic                    chg_any
);

    if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
        $error("parallel_io_bank: N_OUT must be 1..16");
    end
    if (N_IN < 1 || N_IN > DATA_W) begin : g_bad_n_in
        $error("parallel_io_bank: N_IN must be 1..DATA_W");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("parallel_io_bank: DEB_CYCLES must be >= 1");
    end

    logic [N_OUT-1:0][DATA_W-1:0] dout_q, dout_d;
    logic [N_IN-1:0][DATA_W-1:0]  din_w;
    logic [N_IN-1:0][DATA_W-1:0]  sync1_q, sync2_q;
    logic [N_IN-1:0][DATA_W-1:0]  stable;
    logic [N_IN-1:0]              flag_q, flag_d, flag_set, flag_clr;

    assign din_w   = din;
    assign dout    = dout_q;
    assign chg_any = |flag_q;

    always_comb begin
        dout_d = dout_q;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (we && (addr == OUT_BASE + ADDR_W'(k))) begin
                dout_d[k] = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            flag_q  <= '0;
        end else begin
            dout_q  <= dout_d;
            sync1_q <= din_w;
            sync2_q <= sync1_q;
            flag_q  <= flag_d;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic [N_IN-1:0][DATA_W-1:0] stable_q, stable_d;
    logic [N_IN-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        flag_set = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (sync2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_W'(DEB_CYCLES - 1)) begin
                stable_d[k] = sync2_q[k];
                cnt_d[k]    = '0;
                flag_set[k] = 1'b1;
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
`else
    // Without debounce the second sync flop is the stable value (2-edge latency); the flag
    // is raised on the same edge that loads a new value into it.
    assign stable = sync2_q;

    always_comb begin
        flag_set = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            flag_set[k] = (sync1_q[k] != sync2_q[k]);
        end
    end
`endif

    // Set wins over a simultaneous write-1-to-clear on the same bit.
    always_comb begin
        flag_clr = '0;
        if (we && (addr == STAT_ADDR)) begin
            flag_clr = wdata[N_IN-1:0];
        end
        flag_d = (flag_q & ~flag_clr) | flag_set;
    end

    always_comb begin
        rdata = mem_rdata;
        if (addr == STAT_ADDR) begin
            rdata = DATA_W'(flag_q);
        end
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (addr == IN_BASE + ADDR_W'(k)) begin
                rdata = stable[k];
            end
        end
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (addr == OUT_BASE + ADDR_W'(k)) begin
                rdata = dout_q[k];
            end
        end
    end

endmodule
